// File: rtl/dcache_axi_refill_buf_pkg.sv
// rtl/dcache_axi_refill_buf_pkg.sv - shared types and AXI constants for the D-cache refill buffer
package dcache_axi_refill_buf_pkg;

  // Read-side FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Line geometry: 16 x 32-bit words, 64-byte line
  localparam int LINE_WORDS = 16;
  localparam int LINE_OFF_W = 6;
  localparam int BEAT_IDX_W = 4;

  // AXI encodings used on the read channels
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'd2;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Round an address down to the start of its cache line
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_axi_refill_buf_line_beat_packer.sv
// rtl/dcache_axi_refill_buf_line_beat_packer.sv - word-indexed line register with clear
module dcache_axi_refill_buf_line_beat_packer
  import dcache_axi_refill_buf_pkg::*;
#(
  parameter int WORDS = LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [BEAT_IDX_W-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [32*WORDS-1:0]   o_line
);

  logic [32*WORDS-1:0] r_line;

  // Clear the whole line on reset or a new request; otherwise load the selected word on a beat
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_line <= '0;
    end else if (i_we) begin
      for (int k = 0; k < WORDS; k++) begin
        if (i_idx == BEAT_IDX_W'(k)) begin
          r_line[32*k +: 32] <= i_wdata;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/dcache_axi_refill_buf.sv
// rtl/dcache_axi_refill_buf.sv - D-cache AXI read stage collecting refill beats into a line buffer
module dcache_axi_refill_buf #(
  parameter int         LINE_WORDS = dcache_axi_refill_buf_pkg::LINE_WORDS,
  parameter logic [3:0] ARID_VAL   = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic                    rd_uncache,
  input  logic [31:0]             rd_addr,
  input  logic [2:0]              rd_size,
  output logic                    rd_rdy,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [32*LINE_WORDS-1:0] r_data_AXI,
  output logic                    fill_done,
  output logic                    fill_err,
  output logic [3:0]              beat_cnt
);

  import dcache_axi_refill_buf_pkg::state_e;
  import dcache_axi_refill_buf_pkg::ST_IDLE;
  import dcache_axi_refill_buf_pkg::ST_AR;
  import dcache_axi_refill_buf_pkg::ST_R;
  import dcache_axi_refill_buf_pkg::ST_DONE;
  import dcache_axi_refill_buf_pkg::BEAT_IDX_W;
  import dcache_axi_refill_buf_pkg::BURST_INCR;
  import dcache_axi_refill_buf_pkg::SIZE_WORD;
  import dcache_axi_refill_buf_pkg::RESP_SLVERR;
  import dcache_axi_refill_buf_pkg::line_align;

  localparam logic [BEAT_IDX_W-1:0] CNT_MAX    = BEAT_IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]            LINE_ARLEN = 8'(LINE_WORDS - 1);

  state_e                r_state;
  state_e                w_state_nxt;

  logic [31:0]           r_addr;
  logic                  r_uncache;
  logic [2:0]            r_size;
  logic [BEAT_IDX_W-1:0] r_beat_cnt;
  logic                  r_top_filled;
  logic                  r_fill_err;

  logic                  w_rd_rdy;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_fill_done;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_at_top;
  logic                  w_overflow;
  logic                  w_short;
  logic                  w_beat_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; the block only talks to one channel per state
  always_comb begin
    w_state_nxt = r_state;
    w_rd_rdy    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_fill_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rd_rdy = 1'b1;
        if (rd_req) begin
          w_state_nxt = ST_AR;
        end
      end
      ST_AR: begin
        w_arvalid = 1'b1;
        if (arready) begin
          w_state_nxt = ST_R;
        end
      end
      ST_R: begin
        w_rready = 1'b1;
        if (rvalid && rlast) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_fill_done = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept   = w_rd_rdy && rd_req;
  assign w_beat     = w_rready && rvalid;
  assign w_at_top   = (r_beat_cnt == CNT_MAX);
  // A beat arriving after the last word slot was already written is surplus data
  assign w_overflow = w_at_top && r_top_filled;
  // A refill must end exactly on the beat that fills the last slot
  assign w_short    = rlast && !r_uncache && !(w_at_top && !r_top_filled);
  assign w_beat_err = (|(rresp & RESP_SLVERR)) || w_overflow || w_short;

  // Latch the request, count beats and accumulate the sticky error for the transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_uncache    <= 1'b0;
      r_size       <= '0;
      r_beat_cnt   <= '0;
      r_top_filled <= 1'b0;
      r_fill_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr       <= rd_addr;
      r_uncache    <= rd_uncache;
      r_size       <= rd_size;
      r_beat_cnt   <= '0;
      r_top_filled <= 1'b0;
      r_fill_err   <= 1'b0;
    end else if (w_beat) begin
      if (w_at_top) begin
        r_top_filled <= 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      r_fill_err <= r_fill_err | w_beat_err;
    end
  end

  dcache_axi_refill_buf_line_beat_packer #(
    .WORDS (LINE_WORDS)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_we    (w_beat),
    .i_idx   (r_beat_cnt),
    .i_wdata (rdata),
    .o_line  (r_data_AXI)
  );

  // AR fields come only from latched state so they hold steady while arvalid is up
  assign araddr    = r_uncache ? r_addr : line_align(r_addr);
  assign arlen     = r_uncache ? 8'd0 : LINE_ARLEN;
  assign arsize    = r_uncache ? r_size : SIZE_WORD;
  assign arburst   = BURST_INCR;
  assign arid      = ARID_VAL;
  assign arvalid   = w_arvalid;
  assign rready    = w_rready;
  assign rd_rdy    = w_rd_rdy;
  assign fill_done = w_fill_done;
  assign fill_err  = r_fill_err;
  assign beat_cnt  = r_beat_cnt;

endmodule
